// File: rtl/mega_jsoc_sysid_checker.sv
// Reads the sysid slave (ID word, then timestamp word) and compares both against expected constants.
// Optional stall timeout is enabled by defining SYSID_CHECK_TIMEOUT_EN.
module mega_jsoc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd29,
  parameter logic [31:0] EXPECTED_TS    = 32'd1718188374,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sid_address,
  output logic        sid_read,
  input  logic        sid_waitrequest,
  input  logic [31:0] sid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  // Last latency-counter value: the LAT_* cycle that lands exactly READ_LATENCY cycles after acceptance.
  localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t      state_r, next_state_s;
  logic [1:0]  lat_cnt_r;
  logic        accept_s, cap_id_s, cap_ts_s, abort_s, stall_limit_s;
  logic        sid_address_r, sid_read_r, busy_r, done_r;
  logic        id_match_r, ts_match_r, timeout_r;
  logic [31:0] id_value_r, ts_value_r;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_cnt_r;

  // Consecutive stalled read cycles; cleared on acceptance or outside RD_*.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == RD_ID || state_r == RD_TS) && sid_waitrequest) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= 16'd0;
    end
  end

  assign stall_limit_s = (stall_cnt_r == STALL_LAST);
`else
  // No stall limit in this build; the parameter is still referenced so both builds share one interface.
  assign stall_limit_s = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

  // Next-state decode and capture/abort strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    cap_id_s     = 1'b0;
    cap_ts_s     = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = RD_ID;
        else       next_state_s = IDLE;
      end
      RD_ID: begin
        if (!sid_waitrequest) begin
          accept_s = 1'b1;
          if (READ_LATENCY == 0) begin
            cap_id_s     = 1'b1;
            next_state_s = RD_TS;
          end else begin
            next_state_s = LAT_ID;
          end
        end else if (stall_limit_s) begin
          abort_s      = 1'b1;
          next_state_s = FIN;
        end else begin
          next_state_s = RD_ID;
        end
      end
      LAT_ID: begin
        if (lat_cnt_r == LAT_LAST) begin
          cap_id_s     = 1'b1;
          next_state_s = RD_TS;
        end else begin
          next_state_s = LAT_ID;
        end
      end
      RD_TS: begin
        if (!sid_waitrequest) begin
          accept_s = 1'b1;
          if (READ_LATENCY == 0) begin
            cap_ts_s     = 1'b1;
            next_state_s = FIN;
          end else begin
            next_state_s = LAT_TS;
          end
        end else if (stall_limit_s) begin
          abort_s      = 1'b1;
          next_state_s = FIN;
        end else begin
          next_state_s = RD_TS;
        end
      end
      LAT_TS: begin
        if (lat_cnt_r == LAT_LAST) begin
          cap_ts_s     = 1'b1;
          next_state_s = FIN;
        end else begin
          next_state_s = LAT_TS;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, latency counter and strobe outputs; strobes are registered from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      lat_cnt_r     <= 2'd0;
      sid_read_r    <= 1'b0;
      sid_address_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      sid_read_r    <= (next_state_s == RD_ID) || (next_state_s == RD_TS);
      sid_address_r <= (next_state_s == RD_TS);
      busy_r        <= (next_state_s != IDLE);
      done_r        <= (next_state_s == FIN);
      if (accept_s) begin
        lat_cnt_r <= 2'd0;
      end else if (state_r == LAT_ID || state_r == LAT_TS) begin
        lat_cnt_r <= lat_cnt_r + 2'd1;
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
    end
  end

  // Captured words and result flags; held until the next accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
      id_match_r <= 1'b0;
      ts_match_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else if (state_r == IDLE && start) begin
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
      id_match_r <= 1'b0;
      ts_match_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else if (cap_id_s) begin
      id_value_r <= sid_readdata;
      id_match_r <= (sid_readdata == EXPECTED_ID);
    end else if (cap_ts_s) begin
      ts_value_r <= sid_readdata;
      ts_match_r <= (sid_readdata == EXPECTED_TS);
    end else if (abort_s) begin
      id_match_r <= 1'b0;
      ts_match_r <= 1'b0;
      timeout_r  <= 1'b1;
    end else begin
      id_value_r <= id_value_r;
      ts_value_r <= ts_value_r;
      id_match_r <= id_match_r;
      ts_match_r <= ts_match_r;
      timeout_r  <= timeout_r;
    end
  end

  assign sid_read    = sid_read_r;
  assign sid_address = sid_address_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_match    = id_match_r;
  assign ts_match    = ts_match_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_mega_jsoc_sysid_checker.sv
// Directed bench for mega_jsoc_sysid_checker with a small latency-1 sysid slave model.
// The timeout scenario depends on whether SYSID_CHECK_TIMEOUT_EN is defined.
module tb_mega_jsoc_sysid_checker;

  localparam logic [31:0] TS_WORD = 32'd1718188374;

  logic        clock, reset_n, start;
  logic        sid_address, sid_read, sid_waitrequest;
  logic [31:0] sid_readdata;
  logic        busy, done, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  int          n_vec, n_err, stab_err, stall_cycles, done_k, done_seen;
  logic        stuck_wait;
  logic [31:0] id_word;
  logic        pend_valid, pend_addr, prev_hold, prev_addr;
  int          rd_cycles;

  mega_jsoc_sysid_checker #(
    .EXPECTED_ID(32'd29), .EXPECTED_TS(TS_WORD), .READ_LATENCY(1), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .sid_address(sid_address), .sid_read(sid_read), .sid_waitrequest(sid_waitrequest),
    .sid_readdata(sid_readdata), .busy(busy), .done(done),
    .id_match(id_match), .ts_match(ts_match), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Slave model: stall a programmable number of cycles per read, return data one cycle after acceptance.
  assign sid_waitrequest = stuck_wait | (sid_read && (rd_cycles < stall_cycles));
  assign sid_readdata    = pend_valid ? (pend_addr ? TS_WORD : id_word) : 32'hDEAD_BEEF;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= 1'b0;
      rd_cycles  <= 0;
    end else begin
      pend_valid <= sid_read && !sid_waitrequest;
      pend_addr  <= sid_address;
      if (!sid_read || !sid_waitrequest) rd_cycles <= 0;
      else                               rd_cycles <= rd_cycles + 1;
    end
  end

  // Address/read must hold while a read is stalled (an aborted read is exempt).
  always @(negedge clock) begin
    if (reset_n && prev_hold && !timeout && !(sid_read && sid_address == prev_addr))
      stab_err = stab_err + 1;
    prev_hold = reset_n && sid_read && sid_waitrequest;
    prev_addr = sid_address;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_read"},  {31'd0, sid_read}, 32'd0);
    check_eq({tag, "_addr"},  {31'd0, sid_address}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
    check_eq({tag, "_idm"},   {31'd0, id_match}, 32'd0);
    check_eq({tag, "_tsm"},   {31'd0, ts_match}, 32'd0);
    check_eq({tag, "_tmo"},   {31'd0, timeout}, 32'd0);
    check_eq({tag, "_idv"},   id_value, 32'd0);
    check_eq({tag, "_tsv"},   ts_value, 32'd0);
  endtask

  // Pulse start, return the cycle index (start cycle = 0) in which done is seen, or -1.
  task automatic run_check(input int restart_k, input bit restart_fin, output int dk);
    int k;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0; k = 1;
    check_eq("busy_c1", {31'd0, busy}, 32'd1);
    while (!done && k < 80) begin
      start = (k == restart_k);
      @(posedge clock); #1;
      k = k + 1;
    end
    dk = done ? k : -1;
    start = restart_fin;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("post_busy", {31'd0, busy}, 32'd0);
    check_eq("post_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; stab_err = 0; prev_hold = 1'b0; prev_addr = 1'b0;
    reset_n = 1'b0; start = 1'b0; stuck_wait = 1'b0; stall_cycles = 0; id_word = 32'd29;
    #12;
    check_all_zero("rst");
    @(negedge clock); reset_n = 1'b1;

    // Nominal zero-wait check
    run_check(0, 1'b0, done_k);
    check_eq("nom_done_cyc", done_k, 32'd5);
    check_eq("nom_idm", {31'd0, id_match}, 32'd1);
    check_eq("nom_tsm", {31'd0, ts_match}, 32'd1);
    check_eq("nom_idv", id_value, 32'd29);
    check_eq("nom_tsv", ts_value, TS_WORD);
    check_eq("nom_tmo", {31'd0, timeout}, 32'd0);

    // Wrong ID word
    id_word = 32'd30;
    run_check(0, 1'b0, done_k);
    check_eq("badid_done_cyc", done_k, 32'd5);
    check_eq("badid_idm", {31'd0, id_match}, 32'd0);
    check_eq("badid_tsm", {31'd0, ts_match}, 32'd1);
    check_eq("badid_idv", id_value, 32'd30);
    id_word = 32'd29;

    // Three stall cycles per read
    stall_cycles = 3;
    run_check(0, 1'b0, done_k);
    check_eq("stall_done_cyc", done_k, 32'd11);
    check_eq("stall_idm", {31'd0, id_match}, 32'd1);
    check_eq("stall_tsm", {31'd0, ts_match}, 32'd1);
    check_eq("stall_stable", stab_err, 32'd0);
    stall_cycles = 0;

    // start re-pulsed while busy and again in FIN
    run_check(2, 1'b1, done_k);
    check_eq("restart_done_cyc", done_k, 32'd5);
    check_eq("restart_idm", {31'd0, id_match}, 32'd1);
    check_eq("restart_tsm", {31'd0, ts_match}, 32'd1);

    // Reset in LAT_TS: outputs clear at once, no done afterwards
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("latts_read", {31'd0, sid_read}, 32'd0);
    check_eq("latts_idv", id_value, 32'd29);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clock); reset_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (done) done_seen = done_seen + 1;
    end
    check_eq("midrst_nodone", done_seen, 32'd0);
    run_check(0, 1'b0, done_k);
    check_eq("fresh_done_cyc", done_k, 32'd5);
    check_eq("fresh_idm", {31'd0, id_match}, 32'd1);

    // Waitrequest stuck high
    stuck_wait = 1'b1;
`ifdef SYSID_CHECK_TIMEOUT_EN
    run_check(0, 1'b0, done_k);
    check_eq("tmo_done_cyc", done_k, 32'd5);
    check_eq("tmo_flag", {31'd0, timeout}, 32'd1);
    check_eq("tmo_idm", {31'd0, id_match}, 32'd0);
    check_eq("tmo_tsm", {31'd0, ts_match}, 32'd0);
    check_eq("tmo_read", {31'd0, sid_read}, 32'd0);
    stuck_wait = 1'b0;
`else
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_seen = done_seen + 1;
    end
    check_eq("stuck_nodone", done_seen, 32'd0);
    check_eq("stuck_tmo", {31'd0, timeout}, 32'd0);
    check_eq("stuck_read", {31'd0, sid_read}, 32'd1);
    check_eq("stuck_addr", {31'd0, sid_address}, 32'd0);
    stuck_wait = 1'b0;
    reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
`endif
    run_check(0, 1'b0, done_k);
    check_eq("final_done_cyc", done_k, 32'd5);
    check_eq("final_tmo", {31'd0, timeout}, 32'd0);
    check_eq("final_tsm", {31'd0, ts_match}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
